// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared opcode constants, issuer FSM state type and the
//                packed command record used by the ALU command issuer.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int ALU_W = 16;

    localparam logic [3:0] OP_AND   = 4'd0;
    localparam logic [3:0] OP_NOT_A = 4'd1;
    localparam logic [3:0] OP_NOT_B = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_NOR   = 4'd4;
    localparam logic [3:0] OP_NAND  = 4'd5;
    localparam logic [3:0] OP_XOR   = 4'd6;
    localparam logic [3:0] OP_XNOR  = 4'd7;
    localparam logic [3:0] OP_ADD   = 4'd8;
    localparam logic [3:0] OP_MUL   = 4'd9;
    localparam logic [3:0] OP_DIV   = 4'd10;
    localparam logic [3:0] OP_NOOP  = 4'd11;
    localparam logic [3:0] OP_SRL   = 4'd12;
    localparam logic [3:0] OP_SLL   = 4'd13;
    localparam logic [3:0] OP_RSVD  = 4'd14;
    localparam logic [3:0] OP_CLR   = 4'd15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        RESP   = 2'd3
    } state_t;

    // One queued command: 4 + 16 + 16 = 36 bits
    typedef struct packed {
        logic [3:0]       opcode;
        logic [ALU_W-1:0] a;
        logic [ALU_W-1:0] b;
    } cmd_t;

endpackage
`default_nettype wire

// File: rtl/alu_cmd_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : alu_cmd_fifo
//  Description : DEPTH-entry synchronous FIFO of ALU commands with full and
//                empty flags. Push is ignored when full, pop when empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic push,
    input  cmd_t wdata,
    input  logic pop,
    output cmd_t rdata,
    output logic full,
    output logic empty
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH) + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    cmd_t               r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign full      = (r_count == c_FULL);
    assign empty     = (r_count == '0);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign rdata     = r_mem[r_rd_ptr];

    // Storage array; contents need no reset because the count gates reads
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_cmd_issuer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_cmd_issuer
//  Description : Buffers ALU commands, drives them one at a time into the
//                free-running ALU input registers, captures the result at
//                the fixed sample point and returns it over valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_opcode,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [3:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_error,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [3:0]       rsp_opcode,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_error
);

    state_t           r_state;
    state_t           w_next_state;
    logic             w_pop;
    cmd_t             w_head;
    cmd_t             w_wdata;
    logic             w_full;
    logic             w_empty;

    logic [3:0]       r_alu_opcode;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [3:0]       r_cur_op;
    logic             r_rsvd;
    logic             r_rsp_valid;
    logic [3:0]       r_rsp_opcode;
    logic [WIDTH-1:0] r_rsp_result;
    logic             r_rsp_error;

    assign w_wdata    = '{opcode: cmd_opcode, a: cmd_a, b: cmd_b};
    assign cmd_ready  = !w_full;
    assign alu_opcode = r_alu_opcode;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_opcode = r_rsp_opcode;
    assign rsp_result = r_rsp_result;
    assign rsp_error  = r_rsp_error;

    alu_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (cmd_valid),
        .wdata   (w_wdata),
        .pop     (w_pop),
        .rdata   (w_head),
        .full    (w_full),
        .empty   (w_empty)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and pop decision; a reserved opcode bypasses DRIVE
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = (w_head.opcode == OP_RSVD) ? SAMPLE : DRIVE;
                end
            end
            DRIVE: begin
                w_next_state = SAMPLE;
            end
            SAMPLE: begin
                w_next_state = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_next_state = (w_head.opcode == OP_RSVD) ? SAMPLE : DRIVE;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // ALU drive and response capture registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_alu_opcode <= OP_NOOP;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_cur_op     <= '0;
            r_rsvd       <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_opcode <= '0;
            r_rsp_result <= '0;
            r_rsp_error  <= 1'b0;
        end else begin
            if (w_pop) begin
                r_cur_op <= w_head.opcode;
                r_rsvd   <= (w_head.opcode == OP_RSVD);
                // The reserved opcode never reaches the ALU
                if (w_head.opcode != OP_RSVD) begin
                    r_alu_opcode <= w_head.opcode;
                    r_alu_a      <= w_head.a;
                    r_alu_b      <= w_head.b;
                end
            end
            if (r_state == SAMPLE) begin
                r_rsp_valid  <= 1'b1;
                r_rsp_opcode <= r_cur_op;
                r_alu_opcode <= OP_NOOP;
                if (r_rsvd) begin
                    r_rsp_result <= '0;
                    r_rsp_error  <= 1'b1;
                end else begin
                    r_rsp_result <= alu_result;
                    r_rsp_error  <= alu_error;
                end
            end else if ((r_state == RESP) && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_issuer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_cmd_issuer
//  Description : Self-checking bench for alu_cmd_issuer with a behavioural
//                ALU and a transaction-level expected-response queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_issuer;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_opcode;
    logic [15:0] cmd_a;
    logic [15:0] cmd_b;
    logic [3:0]  alu_opcode;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_result;
    logic        alu_error;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [3:0]  rsp_opcode;
    logic [15:0] rsp_result;
    logic        rsp_error;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] res;
        logic        err;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    alu_cmd_issuer #(.DEPTH(4), .WIDTH(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_opcode (cmd_opcode),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .alu_error  (alu_error),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_opcode (rsp_opcode),
        .rsp_result (rsp_result),
        .rsp_error  (rsp_error)
    );

    // Behavioural 16-bit ALU: {error, result}
    function automatic logic [16:0] alu_eval(input logic [3:0] op, input logic [15:0] a,
                                             input logic [15:0] b);
        logic [31:0] p;
        logic [16:0] s;
        alu_eval = 17'd0;
        case (op)
            OP_AND:   alu_eval = {1'b0, a & b};
            OP_NOT_A: alu_eval = {1'b0, ~a};
            OP_NOT_B: alu_eval = {1'b0, ~b};
            OP_OR:    alu_eval = {1'b0, a | b};
            OP_NOR:   alu_eval = {1'b0, ~(a | b)};
            OP_NAND:  alu_eval = {1'b0, ~(a & b)};
            OP_XOR:   alu_eval = {1'b0, a ^ b};
            OP_XNOR:  alu_eval = {1'b0, ~(a ^ b)};
            OP_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                alu_eval = s;
            end
            OP_MUL: begin
                p = {16'd0, a} * {16'd0, b};
                alu_eval = {(p[31:16] != 16'd0), p[15:0]};
            end
            OP_DIV:   alu_eval = (b == 16'd0) ? {1'b1, 16'd0} : {1'b0, a / b};
            OP_SRL:   alu_eval = {1'b0, a >> b[3:0]};
            OP_SLL:   alu_eval = {1'b0, a << b[3:0]};
            default:  alu_eval = 17'd0;
        endcase
    endfunction

    // Expected response for one accepted command
    function automatic exp_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        logic [16:0] r;
        e.op = op;
        if (op == OP_RSVD) begin
            e.res = 16'd0;
            e.err = 1'b1;
        end else begin
            r = alu_eval(op, a, b);
            e.res = r[15:0];
            e.err = r[16];
        end
        return e;
    endfunction

    // ALU with registered inputs; NOOP holds the last computed output
    logic [3:0]  m_op = OP_NOOP;
    logic [15:0] m_a = 16'd0, m_b = 16'd0, m_hold_res = 16'd0;
    logic        m_hold_err = 1'b0;
    logic [16:0] m_now;
    assign m_now      = alu_eval(m_op, m_a, m_b);
    assign alu_result = (m_op == OP_NOOP) ? m_hold_res : m_now[15:0];
    assign alu_error  = (m_op == OP_NOOP) ? m_hold_err : m_now[16];
    always @(posedge clk) begin
        if (m_op != OP_NOOP) begin
            m_hold_res <= m_now[15:0];
            m_hold_err <= m_now[16];
        end
        m_op <= alu_opcode;
        m_a  <= alu_a;
        m_b  <= alu_b;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic v, input logic [3:0] op, input logic [15:0] a,
                           input logic [15:0] b);
        cmd_valid  = v;
        cmd_opcode = op;
        cmd_a      = a;
        cmd_b      = b;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        set_cmd(1'b0, 4'd0, 16'd0, 16'd0);
        rsp_ready = 1'b0;
        repeat (3) tick();
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%0b want=1", cmd_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%0b want=0", rsp_valid); end
        total++; if (alu_opcode !== OP_NOOP) begin bad++; $display("FAIL reset_alu_opcode got=%0d want=11", alu_opcode); end
        total++; if ({alu_a, alu_b} !== 32'd0) begin bad++; $display("FAIL reset_alu_ab got=%0h/%0h want=0/0", alu_a, alu_b); end
        total++; if ({rsp_opcode, rsp_result, rsp_error} !== 21'd0) begin bad++; $display("FAIL reset_rsp got=%0d/%0d/%0b want=0/0/0", rsp_opcode, rsp_result, rsp_error); end
        reset_n = 1'b1;
        repeat (3) tick();
        total++; if (rsp_valid !== 1'b0 || alu_opcode !== OP_NOOP) begin bad++; $display("FAIL idle_after_reset rsp_valid=%0b alu_opcode=%0d want 0/11", rsp_valid, alu_opcode); end
    endtask

    task automatic test_div_latency();
        rsp_ready = 1'b1;
        set_cmd(1'b1, OP_DIV, 16'd40000, 16'd5);
        tick();                                    // e0: accepted
        set_cmd(1'b0, 4'd0, 16'd0, 16'd0);
        tick();                                    // e1: loaded
        total++; if (alu_opcode !== OP_DIV || alu_a !== 16'd40000 || alu_b !== 16'd5) begin bad++; $display("FAIL div_load got=%0d/%0d/%0d want=10/40000/5", alu_opcode, alu_a, alu_b); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL div_early_e1 rsp_valid=%0b want=0", rsp_valid); end
        tick();                                    // e2: ALU samples
        total++; if (rsp_valid !== 1'b0 || alu_opcode !== OP_DIV) begin bad++; $display("FAIL div_e2 rsp_valid=%0b alu_opcode=%0d want 0/10", rsp_valid, alu_opcode); end
        tick();                                    // e3: response
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL div_rsp_valid got=%0b want=1", rsp_valid); end
        total++; if (rsp_result !== 16'd8000 || rsp_error !== 1'b0 || rsp_opcode !== OP_DIV) begin bad++; $display("FAIL div_rsp got=%0d/%0b/op%0d want=8000/0/op10", rsp_result, rsp_error, rsp_opcode); end
        total++; if (alu_opcode !== OP_NOOP) begin bad++; $display("FAIL div_noop got=%0d want=11", alu_opcode); end
        tick();
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL div_handshake rsp_valid=%0b want=0", rsp_valid); end
    endtask

    task automatic test_mul_sll();
        logic [15:0] want_res[2] = '{16'd3392, 16'd32};
        logic        want_err[2] = '{1'b1, 1'b0};
        logic [3:0]  want_op[2]  = '{OP_MUL, OP_SLL};
        int got = 0;
        rsp_ready = 1'b1;
        set_cmd(1'b1, OP_MUL, 16'd200, 16'd1000);
        tick();
        set_cmd(1'b1, OP_SLL, 16'd2, 16'd4);
        tick();
        set_cmd(1'b0, 4'd0, 16'd0, 16'd0);
        for (int c = 0; c < 30 && got < 2; c++) begin
            if (rsp_valid) begin
                total++;
                if (rsp_opcode !== want_op[got] || rsp_result !== want_res[got] || rsp_error !== want_err[got]) begin
                    bad++; $display("FAIL mul_sll_rsp%0d got=op%0d/%0d/%0b want=op%0d/%0d/%0b", got, rsp_opcode, rsp_result, rsp_error, want_op[got], want_res[got], want_err[got]);
                end
                got++;
            end
            tick();
        end
        total++; if (got != 2) begin bad++; $display("FAIL mul_sll_count got=%0d want=2", got); end
    endtask

    task automatic test_back_pressure();
        exp_t q[$];
        exp_t e;
        logic [3:0]  op;
        logic [15:0] a, b;
        int got = 0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            do op = 4'($urandom_range(0, 15)); while (op == OP_NOOP || op == OP_RSVD);
            a = 16'($urandom); b = 16'($urandom);
            set_cmd(1'b1, op, a, b);
            total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_%0d got=0 want=1", i); end
            q.push_back(model(op, a, b));
            tick();
        end
        set_cmd(1'b1, OP_ADD, 16'd1, 16'd1);       // sixth command must be refused
        total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL bp_full got=%0b want=0", cmd_ready); end
        repeat (3) tick();
        total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL bp_full_hold got=%0b want=0", cmd_ready); end
        total++; if (rsp_valid !== 1'b1 || rsp_opcode !== q[0].op || rsp_result !== q[0].res || rsp_error !== q[0].err) begin
            bad++; $display("FAIL bp_park got=%0b/op%0d/%0d/%0b want=1/op%0d/%0d/%0b", rsp_valid, rsp_opcode, rsp_result, rsp_error, q[0].op, q[0].res, q[0].err);
        end
        set_cmd(1'b0, 4'd0, 16'd0, 16'd0);
        rsp_ready = 1'b1;
        for (int c = 0; c < 60 && q.size() > 0; c++) begin
            if (rsp_valid) begin
                e = q.pop_front();
                total++;
                if (rsp_opcode !== e.op || rsp_result !== e.res || rsp_error !== e.err) begin
                    bad++; $display("FAIL bp_drain%0d got=op%0d/%0d/%0b want=op%0d/%0d/%0b", got, rsp_opcode, rsp_result, rsp_error, e.op, e.res, e.err);
                end
                got++;
            end
            tick();
        end
        total++; if (got != 5) begin bad++; $display("FAIL bp_drain_count got=%0d want=5", got); end
    endtask

    task automatic test_reserved();
        logic [15:0] a0, b0;
        int seen_non_noop = 0;
        rsp_ready = 1'b1;
        a0 = alu_a; b0 = alu_b;
        set_cmd(1'b1, OP_RSVD, 16'd7, 16'd9);
        tick();                                    // e0
        set_cmd(1'b0, 4'd0, 16'd0, 16'd0);
        if (alu_opcode !== OP_NOOP) seen_non_noop++;
        tick();                                    // e1
        if (alu_opcode !== OP_NOOP) seen_non_noop++;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rsvd_e1 rsp_valid=%0b want=0", rsp_valid); end
        tick();                                    // e2
        if (alu_opcode !== OP_NOOP) seen_non_noop++;
        total++; if (rsp_valid !== 1'b1 || rsp_result !== 16'd0 || rsp_error !== 1'b1 || rsp_opcode !== OP_RSVD) begin
            bad++; $display("FAIL rsvd_rsp got=%0b/op%0d/%0d/%0b want=1/op14/0/1", rsp_valid, rsp_opcode, rsp_result, rsp_error);
        end
        total++; if (seen_non_noop != 0 || alu_a !== a0 || alu_b !== b0) begin bad++; $display("FAIL rsvd_alu_drive non_noop=%0d a=%0d b=%0d want=0/%0d/%0d", seen_non_noop, alu_a, alu_b, a0, b0); end
        tick();
    endtask

    task automatic test_reset_mid();
        int got = 0;
        int stale = 0;
        rsp_ready = 1'b1;
        set_cmd(1'b1, OP_XOR, 16'h00ff, 16'h0f0f);
        tick();                                    // e0
        set_cmd(1'b1, OP_OR, 16'h1234, 16'h4321);
        tick();                                    // e1: DRIVE
        set_cmd(1'b1, OP_AND, 16'hffff, 16'h00aa);
        tick();                                    // e2: SAMPLE, two queued
        set_cmd(1'b0, 4'd0, 16'd0, 16'd0);
        #2 reset_n = 1'b0;
        #1;
        total++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || alu_opcode !== OP_NOOP) begin
            bad++; $display("FAIL mid_reset got=%0b/%0b/%0d want=0/1/11", rsp_valid, cmd_ready, alu_opcode);
        end
        tick();
        reset_n = 1'b1;
        repeat (8) begin
            if (rsp_valid) stale++;
            tick();
        end
        total++; if (stale != 0) begin bad++; $display("FAIL mid_reset_stale got=%0d want=0", stale); end
        set_cmd(1'b1, OP_ADD, 16'd3, 16'd4);
        tick();
        set_cmd(1'b0, 4'd0, 16'd0, 16'd0);
        for (int c = 0; c < 20 && got == 0; c++) begin
            if (rsp_valid) begin
                got++;
                total++; if (rsp_result !== 16'd7 || rsp_error !== 1'b0 || rsp_opcode !== OP_ADD) begin
                    bad++; $display("FAIL mid_reset_add got=op%0d/%0d/%0b want=op8/7/0", rsp_opcode, rsp_result, rsp_error);
                end
            end
            tick();
        end
        total++; if (got != 1) begin bad++; $display("FAIL mid_reset_add_count got=%0d want=1", got); end
    endtask

    task automatic test_random();
        exp_t e;
        logic [3:0]  op;
        logic [15:0] a, b;
        logic        held = 1'b0;
        logic [20:0] held_val = '0;
        for (int c = 0; c < 400; c++) begin
            do op = 4'($urandom_range(0, 15)); while (op == OP_NOOP);
            a = 16'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
            set_cmd(1'($urandom_range(0, 1)), op, a, b);
            rsp_ready = ($urandom_range(0, 9) < 7);
            if (held) begin
                total++; if (rsp_valid !== 1'b1 || {rsp_opcode, rsp_result, rsp_error} !== held_val) begin
                    bad++; $display("FAIL rand_stable cyc=%0d got=%0b/%0h want=1/%0h", c, rsp_valid, {rsp_opcode, rsp_result, rsp_error}, held_val);
                end
            end
            held = rsp_valid && !rsp_ready;
            held_val = {rsp_opcode, rsp_result, rsp_error};
            if (rsp_valid && rsp_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL rand_unexpected cyc=%0d got=op%0d/%0d want=none", c, rsp_opcode, rsp_result);
                end else begin
                    e = exp_q.pop_front();
                    if (rsp_opcode !== e.op || rsp_result !== e.res || rsp_error !== e.err) begin
                        bad++; $display("FAIL rand_rsp cyc=%0d got=op%0d/%0d/%0b want=op%0d/%0d/%0b", c, rsp_opcode, rsp_result, rsp_error, e.op, e.res, e.err);
                    end
                end
            end
            if (cmd_valid && cmd_ready) exp_q.push_back(model(op, a, b));
            tick();
        end
        set_cmd(1'b0, 4'd0, 16'd0, 16'd0);
        rsp_ready = 1'b1;
        for (int c = 0; c < 200 && exp_q.size() > 0; c++) begin
            if (rsp_valid) begin
                e = exp_q.pop_front();
                total++;
                if (rsp_opcode !== e.op || rsp_result !== e.res || rsp_error !== e.err) begin
                    bad++; $display("FAIL rand_drain got=op%0d/%0d/%0b want=op%0d/%0d/%0b", rsp_opcode, rsp_result, rsp_error, e.op, e.res, e.err);
                end
            end
            tick();
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rand_leftover got=%0d want=0", exp_q.size()); end
        repeat (3) tick();
        total++; if (rsp_valid !== 1'b0 || alu_opcode !== OP_NOOP) begin bad++; $display("FAIL rand_idle got=%0b/%0d want=0/11", rsp_valid, alu_opcode); end
    endtask

    initial begin
        test_reset();
        test_div_latency();
        repeat (2) tick();
        test_mul_sll();
        repeat (2) tick();
        test_back_pressure();
        repeat (2) tick();
        test_reserved();
        repeat (2) tick();
        test_reset_mid();
        repeat (2) tick();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
